// File: rtl/msrv32_pkg.sv
// Shared definitions for the data-memory access path: access size encodings,
// access FSM states and the alignment rule.
package msrv32_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10,
    ST_DONE = 2'b11
  } dmem_state_e;

  // Encoding 2'b11 falls into the default arm and is handled as a word access.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lo[0];
      default:   return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/msrv32_store_lane_gen.sv
// Combinational store lane generator: byte strobes and lane-replicated write
// data for a store of the given size at the given byte offset.
module msrv32_store_lane_gen
  import msrv32_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2,
  output logic [3:0]  wr_mask,
  output logic [31:0] wr_data
);

  // NOTE: both outputs get a default before the case so no path leaves them
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_mask = 4'b1111;
    wr_data = rs2;
    case (size)
      SIZE_BYTE: begin
        wr_mask = 4'b0001 << addr_lo;
        wr_data = {4{rs2[7:0]}};
      end
      SIZE_HALF: begin
        wr_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{rs2[15:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/msrv32_dmem_access_unit.sv
// Data-memory access unit: turns a pipeline load/store into one bus transfer
// and hands the response to the load unit, stalling the pipeline meanwhile.
module msrv32_dmem_access_unit
  import msrv32_pkg::*;
(
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        mem_req_in,
  input  logic        mem_wr_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] rs2_in,
  input  logic [1:0]  mem_size_in,
  input  logic        load_unsigned_in,
  input  logic        flush_in,
  output logic [31:0] ms_riscv32_mp_dmaddr_out,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  output logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
  output logic        ms_riscv32_mp_dmreq_out,
  output logic        ms_riscv32_mp_dmwr_req_out,
  input  logic        ms_riscv32_mp_dmready_in,
  input  logic        ms_riscv32_mp_dmrvalid_in,
  input  logic [31:0] ms_riscv32_mp_dmdata_in,
  input  logic        ms_riscv32_mp_ahb_resp_in,
  output logic        stall_out,
  output logic        result_valid_out,
  output logic [31:0] lu_dmdata_out,
  output logic [1:0]  iadder_out_1_to_0_out,
  output logic [1:0]  load_size_out,
  output logic        load_unsigned_out,
  output logic        ahb_resp_out,
  output logic        misaligned_out
);

  dmem_state_e state;
  logic        misaligned;
  logic        accept;
  logic [3:0]  lane_mask;
  logic [31:0] lane_data;

  msrv32_store_lane_gen u_lane_gen (
    .size    (mem_size_in),
    .addr_lo (iadder_in[1:0]),
    .rs2     (rs2_in),
    .wr_mask (lane_mask),
    .wr_data (lane_data)
  );

  assign misaligned = is_misaligned(mem_size_in, iadder_in[1:0]);
  assign accept     = (state == ST_IDLE) && mem_req_in && !flush_in && !misaligned;

  // Gated by reset so the pipeline is never held while the unit is in reset.
  assign stall_out = ms_riscv32_mp_rst_in &&
                     (accept || state == ST_REQ || state == ST_RESP);

  // NOTE: sequential state uses non-blocking assignments only; the synchronous
  // reset clears every registered output so nothing leaks out of an
  // abandoned access.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state                       <= ST_IDLE;
      ms_riscv32_mp_dmaddr_out    <= '0;
      ms_riscv32_mp_dmdata_out    <= '0;
      ms_riscv32_mp_dmwr_mask_out <= '0;
      ms_riscv32_mp_dmreq_out     <= 1'b0;
      ms_riscv32_mp_dmwr_req_out  <= 1'b0;
      result_valid_out            <= 1'b0;
      lu_dmdata_out               <= '0;
      iadder_out_1_to_0_out       <= '0;
      load_size_out               <= '0;
      load_unsigned_out           <= 1'b0;
      ahb_resp_out                <= 1'b0;
      misaligned_out              <= 1'b0;
    end else begin
      result_valid_out <= 1'b0;
      misaligned_out   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state                       <= ST_REQ;
            ms_riscv32_mp_dmaddr_out    <= {iadder_in[31:2], 2'b00};
            ms_riscv32_mp_dmdata_out    <= mem_wr_in ? lane_data : 32'h0;
            ms_riscv32_mp_dmwr_mask_out <= mem_wr_in ? lane_mask : 4'b0000;
            ms_riscv32_mp_dmreq_out     <= 1'b1;
            ms_riscv32_mp_dmwr_req_out  <= mem_wr_in;
            iadder_out_1_to_0_out       <= iadder_in[1:0];
            load_size_out               <= mem_size_in;
            load_unsigned_out           <= load_unsigned_in;
          end else if (mem_req_in && !flush_in && misaligned) begin
            misaligned_out <= 1'b1;
          end
        end
        ST_REQ: begin
          // Bus outputs are only driven while the request is outstanding.
          if (ms_riscv32_mp_dmready_in) begin
            state                       <= ST_RESP;
            ms_riscv32_mp_dmaddr_out    <= '0;
            ms_riscv32_mp_dmdata_out    <= '0;
            ms_riscv32_mp_dmwr_mask_out <= '0;
            ms_riscv32_mp_dmreq_out     <= 1'b0;
            ms_riscv32_mp_dmwr_req_out  <= 1'b0;
          end
        end
        ST_RESP: begin
          // Stores wait for the response too, so bus errors reach the pipeline.
          if (ms_riscv32_mp_dmrvalid_in) begin
            state            <= ST_DONE;
            lu_dmdata_out    <= ms_riscv32_mp_dmdata_in;
            ahb_resp_out     <= ms_riscv32_mp_ahb_resp_in;
            result_valid_out <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msrv32_dmem_access_unit.sv
// Self-checking bench for msrv32_dmem_access_unit: a transaction-level model
// predicts every output each cycle; directed cases pin the model to literals.
module tb_msrv32_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req = 1'b0, mem_wr = 1'b0, load_unsigned = 1'b0, flush = 1'b0;
  logic [31:0] iadder = '0, rs2 = '0;
  logic [1:0]  mem_size = '0;
  logic [31:0] dmaddr, dmdata;
  logic [3:0]  dmwr_mask;
  logic        dmreq, dmwr_req;
  logic        dmready = 1'b0, dmrvalid = 1'b0, ahb_resp_in = 1'b0;
  logic [31:0] dmdata_in = '0;
  logic        stall, result_valid, load_unsigned_o, ahb_resp_o, misaligned;
  logic [31:0] lu_dmdata;
  logic [1:0]  a10, load_size;

  msrv32_dmem_access_unit dut (
    .ms_riscv32_mp_clk_in        (clk),
    .ms_riscv32_mp_rst_in        (rst_n),
    .mem_req_in                  (mem_req),
    .mem_wr_in                   (mem_wr),
    .iadder_in                   (iadder),
    .rs2_in                      (rs2),
    .mem_size_in                 (mem_size),
    .load_unsigned_in            (load_unsigned),
    .flush_in                    (flush),
    .ms_riscv32_mp_dmaddr_out    (dmaddr),
    .ms_riscv32_mp_dmdata_out    (dmdata),
    .ms_riscv32_mp_dmwr_mask_out (dmwr_mask),
    .ms_riscv32_mp_dmreq_out     (dmreq),
    .ms_riscv32_mp_dmwr_req_out  (dmwr_req),
    .ms_riscv32_mp_dmready_in    (dmready),
    .ms_riscv32_mp_dmrvalid_in   (dmrvalid),
    .ms_riscv32_mp_dmdata_in     (dmdata_in),
    .ms_riscv32_mp_ahb_resp_in   (ahb_resp_in),
    .stall_out                   (stall),
    .result_valid_out            (result_valid),
    .lu_dmdata_out               (lu_dmdata),
    .iadder_out_1_to_0_out       (a10),
    .load_size_out               (load_size),
    .load_unsigned_out           (load_unsigned_o),
    .ahb_resp_out                (ahb_resp_o),
    .misaligned_out              (misaligned)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected outputs for the current cycle, maintained by the driver.
  logic        chk_en = 1'b0;
  logic [31:0] exp_dmaddr = '0, exp_dmdata = '0, exp_lu = '0;
  logic [3:0]  exp_mask = '0;
  logic [1:0]  exp_a10 = '0, exp_lsize = '0;
  logic        exp_dmreq = 0, exp_dmwr = 0, exp_stall = 0, exp_rv = 0;
  logic        exp_luns = 0, exp_err = 0, exp_mis = 0;

  int n_req = 0, n_rv = 0, n_mis = 0;

  always @(negedge clk) begin
    if (dmreq === 1'b1)        n_req++;
    if (result_valid === 1'b1) n_rv++;
    if (misaligned === 1'b1)   n_mis++;
    if (chk_en) begin
      check("dmaddr",        dmaddr,             exp_dmaddr);
      check("dmdata",        dmdata,             exp_dmdata);
      check("dmwr_mask",     32'(dmwr_mask),     32'(exp_mask));
      check("dmreq",         32'(dmreq),         32'(exp_dmreq));
      check("dmwr_req",      32'(dmwr_req),      32'(exp_dmwr));
      check("stall",         32'(stall),         32'(exp_stall));
      check("result_valid",  32'(result_valid),  32'(exp_rv));
      check("lu_dmdata",     lu_dmdata,          exp_lu);
      check("iadder_1_to_0", 32'(a10),           32'(exp_a10));
      check("load_size",     32'(load_size),     32'(exp_lsize));
      check("load_unsigned", 32'(load_unsigned_o), 32'(exp_luns));
      check("ahb_resp_out",  32'(ahb_resp_o),    32'(exp_err));
      check("misaligned",    32'(misaligned),    32'(exp_mis));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_exp();
    exp_dmaddr = '0; exp_dmdata = '0; exp_lu = '0; exp_mask = '0;
    exp_a10 = '0; exp_lsize = '0; exp_dmreq = 0; exp_dmwr = 0;
    exp_stall = 0; exp_rv = 0; exp_luns = 0; exp_err = 0; exp_mis = 0;
  endtask

  function automatic logic model_misaligned(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd1) return addr[0];
    if (size >= 2'd2) return addr[1:0] != 2'd0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_mask(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd0) return 4'(1 << addr[1:0]);
    if (size == 2'd1) return 4'(3 << addr[1:0]);
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_data(input logic [1:0] size, input logic [31:0] v);
    if (size == 2'd0) return {24'd0, v[7:0]} * 32'h0101_0101;
    if (size == 2'd1) return {16'd0, v[15:0]} * 32'h0001_0001;
    return v;
  endfunction

  // One access issued from an IDLE cycle; returns in the next IDLE cycle.
  task automatic do_txn(input logic req, input logic wr, input logic [31:0] addr,
                        input logic [1:0] size, input logic [31:0] data, input logic uns,
                        input logic fl, input int rdy_dly, input int rv_dly,
                        input logic [31:0] rdata, input logic err, input logic done_req,
                        output logic [31:0] cap_addr, output logic [3:0] cap_mask,
                        output logic [31:0] cap_data, output int latency);
    logic mis = model_misaligned(size, addr);
    logic acc = req && !fl && !mis;
    int   n0  = cyc;
    cap_addr = '0; cap_mask = '0; cap_data = '0; latency = -1;
    mem_req = req; mem_wr = wr; iadder = addr; mem_size = size; rs2 = data;
    load_unsigned = uns; flush = fl;
    exp_stall = acc;
    tick();
    mem_req = 1'b0; flush = 1'b0; iadder = $urandom; rs2 = $urandom;
    exp_stall = 1'b0;
    if (req && !fl && mis) begin
      exp_mis = 1'b1;
      tick();
      exp_mis = 1'b0;
    end
    if (!acc) return;
    exp_dmreq = 1'b1; exp_dmaddr = addr & 32'hFFFF_FFFC; exp_dmwr = wr;
    exp_mask = wr ? model_mask(size, addr) : 4'h0;
    exp_dmdata = wr ? model_data(size, data) : 32'h0;
    exp_stall = 1'b1; exp_a10 = addr[1:0]; exp_lsize = size; exp_luns = uns;
    #3;
    cap_addr = dmaddr; cap_mask = dmwr_mask; cap_data = dmdata;
    for (int i = 0; i < rdy_dly; i++) begin
      flush = 1'($urandom_range(0, 1));
      tick();
    end
    dmready = 1'b1;
    tick();
    dmready = 1'b0;
    exp_dmreq = 1'b0; exp_dmaddr = '0; exp_dmwr = 1'b0; exp_mask = '0; exp_dmdata = '0;
    for (int i = 0; i < rv_dly; i++) begin
      flush = 1'($urandom_range(0, 1));
      dmdata_in = $urandom;
      tick();
    end
    dmrvalid = 1'b1; dmdata_in = rdata; ahb_resp_in = err;
    tick();
    dmrvalid = 1'b0; dmdata_in = $urandom; ahb_resp_in = 1'b0; flush = 1'b0;
    exp_stall = 1'b0; exp_rv = 1'b1; exp_lu = rdata; exp_err = err;
    latency = cyc - n0;
    if (done_req) begin
      mem_req = 1'b1; mem_wr = 1'b0; iadder = 32'h0000_0100; mem_size = 2'd2;
    end
    tick();
    mem_req = 1'b0;
    exp_rv = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ca, cd;
    logic [3:0]  cm;
    int          lat, r0, q0, m0;

    rst_n = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Byte store to the top lane, zero wait states.
    do_txn(1, 1, 32'h0000_1003, 2'd0, 32'h0000_00A5, 0, 0, 0, 0, 32'h0, 0, 0, ca, cm, cd, lat);
    check("sb_dmaddr",  ca, 32'h0000_1000);
    check("sb_mask",    32'(cm), 32'h8);
    check("sb_data",    cd, 32'hA5A5_A5A5);
    check("sb_latency", 32'(lat), 32'd3);

    // Halfword load, ready delayed 3 cycles.
    do_txn(1, 0, 32'h0000_2002, 2'd1, 32'h0, 0, 0, 3, 1, 32'hBEEF_1234, 0, 0, ca, cm, cd, lat);
    check("lh_lu_dmdata", lu_dmdata, 32'hBEEF_1234);
    check("lh_a10",       32'(a10), 32'h2);
    check("lh_size",      32'(load_size), 32'h1);
    check("lh_latency",   32'(lat), 32'd7);

    // Misaligned word load.
    q0 = n_req; m0 = n_mis;
    do_txn(1, 0, 32'h0000_3001, 2'd2, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, ca, cm, cd, lat);
    tick();
    check("mis_pulses", 32'(n_mis - m0), 32'd1);
    check("mis_no_req", 32'(n_req - q0), 32'd0);

    // Bus error on a word load; a request during DONE is ignored.
    r0 = n_rv;
    do_txn(1, 0, 32'h0000_5000, 2'd2, 32'h0, 1, 0, 1, 2, 32'h1111_2222, 1, 1, ca, cm, cd, lat);
    check("err_resp_out", 32'(ahb_resp_o), 32'd1);
    check("err_one_rv",   32'(n_rv - r0), 32'd1);
    tick();

    // Flush in IDLE drops the request; flush during the access does not.
    q0 = n_req; r0 = n_rv;
    do_txn(1, 1, 32'h0000_6000, 2'd2, 32'h1234_5678, 0, 1, 0, 0, 32'h0, 0, 0, ca, cm, cd, lat);
    tick();
    check("flush_idle_no_req", 32'(n_req - q0), 32'd0);
    do_txn(1, 1, 32'h0000_6004, 2'd3, 32'hCAFE_F00D, 0, 0, 2, 3, 32'h0BAD_0BAD, 0, 0, ca, cm, cd, lat);
    check("flush_resp_done", 32'(n_rv - r0), 32'd1);
    check("size3_mask",      32'(cm), 32'hF);

    // Reset while waiting for the response abandons the access.
    mem_req = 1'b1; mem_wr = 1'b0; iadder = 32'h0000_4000; mem_size = 2'd2;
    load_unsigned = 1'b1; flush = 1'b0;
    exp_stall = 1'b1;
    tick();
    mem_req = 1'b0;
    exp_dmreq = 1'b1; exp_dmaddr = 32'h0000_4000; exp_a10 = 2'd0; exp_lsize = 2'd2;
    exp_luns = 1'b1; exp_stall = 1'b1;
    dmready = 1'b1;
    tick();
    dmready = 1'b0;
    exp_dmreq = 1'b0; exp_dmaddr = '0;
    tick();
    rst_n = 1'b0; chk_en = 1'b0;
    tick();
    rst_n = 1'b1; zero_exp(); chk_en = 1'b1;
    r0 = n_rv;
    dmrvalid = 1'b1; dmdata_in = 32'hDEAD_BEEF;
    tick();
    dmrvalid = 1'b0;
    tick();
    tick();
    check("late_rvalid_ignored", 32'(n_rv - r0), 32'd0);

    // Randomised traffic.
    for (int t = 0; t < 300; t++) begin
      logic [1:0]  sz  = 2'($urandom_range(0, 3));
      logic [31:0] ad  = $urandom;
      logic        rq  = ($urandom_range(0, 9) != 0);
      logic        fl  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 1) ad[1:0] = (sz == 2'd1) ? {ad[1], 1'b0} : (sz >= 2'd2 ? 2'b00 : ad[1:0]);
      do_txn(rq, 1'($urandom_range(0, 1)), ad, sz, $urandom, 1'($urandom_range(0, 1)), fl,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), ca, cm, cd, lat);
    end
    tick();
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/msrv32_dmem_access_unit.md
MSRV32_DMEM_ACCESS_UNIT -- requirements
Module: msrv32_dmem_access_unit

Interface
REQ-001 ms_riscv32_mp_clk_in  input  1  sole clock; all state updates on rising edge.
REQ-002 ms_riscv32_mp_rst_in  input  1  reset; synchronous and active-low.
REQ-003 mem_req_in  input  1  pipeline requests a load or store this cycle.
REQ-004 mem_wr_in  input  1  1 = store, 0 = load; qualified by mem_req_in.
REQ-005 iadder_in  input  32  effective byte address.
REQ-006 rs2_in  input  32  store source data.
REQ-007 mem_size_in  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-008 load_unsigned_in  input  1  load zero-extend flag, carried through.
REQ-009 flush_in  input  1  pipeline kill; affects unissued requests only.
REQ-010 ms_riscv32_mp_dmaddr_out  output  32  word-aligned bus address (low 2 bits 00).
REQ-011 ms_riscv32_mp_dmdata_out  output  32  lane-replicated store data.
REQ-012 ms_riscv32_mp_dmwr_mask_out  output  4  byte-lane write strobes; 0000 for loads.
REQ-013 ms_riscv32_mp_dmreq_out  output  1  bus request valid.
REQ-014 ms_riscv32_mp_dmwr_req_out  output  1  1 = write transfer, qualified by dmreq.
REQ-015 ms_riscv32_mp_dmready_in  input  1  bus accepts request this cycle.
REQ-016 ms_riscv32_mp_dmrvalid_in  input  1  bus response valid.
REQ-017 ms_riscv32_mp_dmdata_in  input  32  bus read data, valid with rvalid.
REQ-018 ms_riscv32_mp_ahb_resp_in  input  1  bus error, valid with rvalid.
REQ-019 stall_out  output  1  holds the pipeline while an access is pending.
REQ-020 result_valid_out  output  1  one-cycle pulse: access complete, downstream outputs valid.
REQ-021 lu_dmdata_out  output  32  captured read word for the load unit.
REQ-022 iadder_out_1_to_0_out, load_size_out, load_unsigned_out  output  2/2/1  registered access attributes for the load unit.
REQ-023 ahb_resp_out  output  1  captured error flag for the load unit.
REQ-024 misaligned_out  output  1  one-cycle pulse: misaligned access rejected.

Function
REQ-025 FSM states IDLE, REQ, RESP, DONE; IDLE after reset.
REQ-026 IDLE: mem_req_in=1, flush_in=0, aligned -> latch addr/data/size/unsigned/wr, go to REQ.
REQ-027 Misalignment: half with addr[0]=1, or word with addr[1:0]!=00 -> misaligned_out=1 next cycle, no bus request, remain in IDLE.
REQ-028 flush_in=1 in IDLE -> request ignored; in REQ/RESP/DONE flush_in is ignored and the issued access completes.
REQ-029 REQ: dmreq_out=1, all bus outputs held stable until dmready_in=1, then go to RESP.
REQ-030 RESP: on dmrvalid_in=1 capture dmdata_in and ahb_resp_in, go to DONE; stores also wait for rvalid.
REQ-031 DONE: result_valid_out=1 for exactly one cycle, go to IDLE; a new request is accepted the following cycle.
REQ-032 stall_out=1 in REQ and RESP, and in IDLE when an aligned unflushed request is present; 0 in DONE.
REQ-033 Minimum latency: request in cycle N -> result_valid_out in cycle N+3 when ready and rvalid are asserted immediately.
REQ-034 Store data: byte {4{rs2[7:0]}}, half {2{rs2[15:0]}}, word rs2.
REQ-035 Store mask: byte 0001<<addr[1:0]; half 0011 (addr[1]=0) or 1100; word 1111.
REQ-036 dmaddr_out = {latched addr[31:2], 2'b00}.
REQ-037 ahb_resp_out=1 at DONE is passed through unchanged; no retry.

Reset
REQ-038 While rst_in=0 at a clock edge: state IDLE; all outputs 0, including dmreq_out, stall_out, result_valid_out, misaligned_out, mask and data.
REQ-039 A reset asserted during REQ or RESP abandons the access; rvalid arriving after reset is ignored.

Structure
REQ-040 Shared package msrv32_pkg holds the size encodings (BYTE/HALF/WORD) and the FSM state enumeration.
REQ-041 Sub-module msrv32_store_lane_gen is purely combinational: inputs size and addr[1:0] plus rs2; outputs mask and replicated data.

Verification
REQ-042 sb 0xA5 to 0x1003 with ready and rvalid immediate -> dmaddr 0x1000, mask 1000, data 0xA5A5A5A5, result_valid in cycle N+3.
REQ-043 lh from 0x2002 with ready delayed 3 cycles and dmdata_in 0xBEEF1234 -> stall high throughout, lu_dmdata 0xBEEF1234, iadder_1_to_0 10, size 01.
REQ-044 lw from 0x3001 -> misaligned_out pulse, dmreq_out never asserted, stall_out 0.
REQ-045 lw with ahb_resp_in=1 at rvalid -> ahb_resp_out=1 in DONE with result_valid 1.
REQ-046 flush_in with request in IDLE -> no transfer; flush_in during RESP -> access completes normally.
REQ-047 rst_in=0 during RESP -> next cycle state IDLE, all outputs 0; a subsequent late rvalid produces no result_valid_out.
